frontier_index_packer: RTL and testbench

Sits directly downstream of the level generator. It consumes the 32-bit newly-visited vertex index stream, rebases each index by a per-partition base offset, and packs index pairs into 64-bit words for the DMA write path. On a flush request it emits any half-filled word padded with a sentinel, then reports completion and counts to the host-side controller.

---
 rtl/frontier_pkg.sv | 17 +
 rtl/axis_reg_slice64.sv | 29 ++
 rtl/frontier_index_packer.sv | 105 ++++++++++
 tb/tb_frontier_index_packer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frontier_pkg.sv
// Shared definitions for the frontier pipeline: the level generator, the
// index packer and the DMA writer all use these widths and this sentinel.
package frontier_pkg;

  localparam int INDEX_W = 32;
  localparam int WORD_W  = 64;

  localparam logic [INDEX_W-1:0] PAD_SENTINEL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/axis_reg_slice64.sv
// Single-entry AXI-Stream output register. The entry is free when it is
// empty or when it is draining in the current cycle.
module axis_reg_slice64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic        ready,
  output logic        valid,
  output logic [63:0] data,
  output logic        free
);

  assign free = !valid || ready;

  // load has priority over drain so a back-to-back refill keeps valid high
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/frontier_index_packer.sv
// Rebases incoming vertex indices by a per-run offset and packs them in pairs
// into 64-bit words; a flush pads any leftover half with the sentinel.
module frontier_index_packer
  import frontier_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INDEX_W-1:0] base_offset,
  input  logic               flush,
  output logic               done,
  output logic [31:0]        index_count,
  output logic [31:0]        word_count,
  output logic               in_TREADY,
  input  logic               in_TVALID,
  input  logic [INDEX_W-1:0] in_TDATA,
  input  logic               out_TREADY,
  output logic               out_TVALID,
  output logic [WORD_W-1:0]  out_TDATA
);

  state_t             state;
  state_t             state_next;
  logic               half;
  logic [INDEX_W-1:0] lo_reg;
  logic [INDEX_W-1:0] base_reg;
  logic [INDEX_W-1:0] rebased;
  logic               slot_free;
  logic               load;
  logic [WORD_W-1:0]  load_data;
  logic               in_hs;
  logic               out_hs;

  assign rebased   = in_TDATA + base_reg;
  assign in_TREADY = (state == COLLECT) && (!half || slot_free);
  assign in_hs     = in_TREADY && in_TVALID;
  assign out_hs    = out_TVALID && out_TREADY;
  assign done      = (state == DONE);

  axis_reg_slice64 u_out_slice (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .ready     (out_TREADY),
    .valid     (out_TVALID),
    .data      (out_TDATA),
    .free      (slot_free)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_data  = {rebased, lo_reg};
    unique case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: begin
        load = in_hs && half;
        if (flush) state_next = FLUSH;
      end
      FLUSH: begin
        if (half && slot_free) begin
          load      = 1'b1;
          load_data = {PAD_SENTINEL, lo_reg};
        end
        // wait for the last word to leave before reporting completion
        if (!half && !out_TVALID) state_next = DONE;
      end
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      half        <= 1'b0;
      lo_reg      <= '0;
      base_reg    <= '0;
      index_count <= '0;
      word_count  <= '0;
    end else begin
      if (state == IDLE && start) begin
        base_reg    <= base_offset;
        half        <= 1'b0;
        index_count <= '0;
        word_count  <= '0;
      end else begin
        if (in_hs) begin
          index_count <= index_count + 32'd1;
          half        <= !half;
          if (!half) lo_reg <= rebased;
        end else if (state == FLUSH && half && slot_free) begin
          half <= 1'b0;
        end
        if (out_hs) word_count <= word_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_frontier_index_packer.sv
// Directed-vector bench for frontier_index_packer; inputs change 1 time unit
// after a rising edge and outputs are observed on the falling edge.
module tb_frontier_index_packer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_offset;
  logic        flush;
  logic        done;
  logic [31:0] index_count;
  logic [31:0] word_count;
  logic        in_TREADY;
  logic        in_TVALID;
  logic [31:0] in_TDATA;
  logic        out_TREADY;
  logic        out_TVALID;
  logic [63:0] out_TDATA;

  int tests_run;
  int tests_failed;
  logic [63:0] got_words[$];

  frontier_index_packer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_offset (base_offset),
    .flush       (flush),
    .done        (done),
    .index_count (index_count),
    .word_count  (word_count),
    .in_TREADY   (in_TREADY),
    .in_TVALID   (in_TVALID),
    .in_TDATA    (in_TDATA),
    .out_TREADY  (out_TREADY),
    .out_TVALID  (out_TVALID),
    .out_TDATA   (out_TDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // an output handshake seen on the falling edge completes on the next rise
  always @(negedge clk) begin
    if (!reset && out_TVALID && out_TREADY) got_words.push_back(out_TDATA);
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] base);
    step();
    got_words.delete();
    base_offset = base;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_index(input logic [31:0] value);
    bit accepted = 1'b0;
    in_TVALID = 1'b1;
    in_TDATA  = value;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (in_TREADY) accepted = 1'b1;
      step();
    end
    in_TVALID = 1'b0;
    if (!accepted) check_output("send_timeout", 64'(value), 64'hDEAD);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_output("done", 64'(done), 64'd1);
  endtask

  task automatic check_words(input string tag, input logic [63:0] exp0,
                             input logic [63:0] exp1, input int n);
    logic [63:0] w0;
    logic [63:0] w1;
    w0 = (got_words.size() > 0) ? got_words[0] : 64'hX;
    w1 = (got_words.size() > 1) ? got_words[1] : 64'hX;
    check_output({tag, "_nwords"}, 64'(got_words.size()), 64'(n));
    check_output({tag, "_word0"}, w0, exp0);
    if (n > 1) check_output({tag, "_word1"}, w1, exp1);
  endtask

  task automatic check_counts(input string tag, input int ni, input int nw);
    check_output({tag, "_index_count"}, 64'(index_count), 64'(ni));
    check_output({tag, "_word_count"}, 64'(word_count), 64'(nw));
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check_output({tag, "_out_valid"}, 64'(out_TVALID), 64'd0);
    check_output({tag, "_out_data"}, out_TDATA, 64'd0);
    check_output({tag, "_in_ready"}, 64'(in_TREADY), 64'd0);
    check_output({tag, "_done"}, 64'(done), 64'd0);
    check_counts(tag, 0, 0);
  endtask

  initial begin
    logic [31:0] bp_data[4];
    int accepted;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    start        = 1'b0;
    flush        = 1'b0;
    base_offset  = '0;
    in_TVALID    = 1'b0;
    in_TDATA     = '0;
    out_TREADY   = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_reset_state("reset");

    // basic pack with an odd count ends in a padded word
    start_run(32'h100);
    send_index(32'd5);
    send_index(32'd7);
    send_index(32'd9);
    pulse_flush();
    wait_done();
    check_words("basic", 64'h00000107_00000105, 64'hFFFFFFFF_00000109, 2);
    check_counts("basic", 3, 2);

    // even count: no pad word
    start_run(32'h0);
    send_index(32'd1);
    send_index(32'd2);
    pulse_flush();
    wait_done();
    check_words("even", 64'h00000002_00000001, 64'h0, 1);
    check_counts("even", 2, 1);

    // backpressure: the first pair fills the output slot, the third index
    // still fits in the empty low half, the fourth must wait
    bp_data = '{32'd1, 32'd2, 32'd3, 32'd4};
    out_TREADY = 1'b0;
    start_run(32'h10);
    accepted  = 0;
    in_TVALID = 1'b1;
    in_TDATA  = bp_data[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_TREADY && accepted < 4) accepted++;
      step();
      if (accepted < 4) in_TDATA = bp_data[accepted];
      else in_TVALID = 1'b0;
    end
    @(negedge clk);
    check_output("bp_accepted", 64'(accepted), 64'd3);
    check_output("bp_in_ready", 64'(in_TREADY), 64'd0);
    check_output("bp_hold_valid", 64'(out_TVALID), 64'd1);
    check_output("bp_hold_data", out_TDATA, 64'h00000012_00000011);
    step();
    out_TREADY = 1'b1;
    for (int i = 0; i < 20 && accepted < 4; i++) begin
      @(negedge clk);
      if (in_TREADY) accepted++;
      step();
    end
    in_TVALID = 1'b0;
    check_output("bp_accepted_all", 64'(accepted), 64'd4);
    pulse_flush();
    wait_done();
    check_words("bp", 64'h00000012_00000011, 64'h00000014_00000013, 2);
    check_counts("bp", 4, 2);

    // rebasing drops the carry
    start_run(32'hFFFF_FFFF);
    send_index(32'd2);
    pulse_flush();
    wait_done();
    check_words("wrap", 64'hFFFFFFFF_00000001, 64'h0, 1);
    check_counts("wrap", 1, 1);

    // flush in the same cycle as the third index handshake
    start_run(32'h0);
    send_index(32'd10);
    send_index(32'd11);
    in_TVALID = 1'b1;
    in_TDATA  = 32'd12;
    flush     = 1'b1;
    @(negedge clk);
    check_output("simul_in_ready", 64'(in_TREADY), 64'd1);
    step();
    in_TVALID = 1'b0;
    flush     = 1'b0;
    wait_done();
    check_words("simul", 64'h0000000B_0000000A, 64'hFFFFFFFF_0000000C, 2);
    check_counts("simul", 3, 2);

    // reset mid-run with a word pending and a half filled
    out_TREADY = 1'b0;
    start_run(32'h0);
    send_index(32'd1);
    send_index(32'd2);
    send_index(32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_TREADY = 1'b1;
    check_reset_state("midreset");
    start_run(32'h20);
    send_index(32'd4);
    send_index(32'd5);
    pulse_flush();
    wait_done();
    check_words("fresh", 64'h00000025_00000024, 64'h0, 1);
    check_counts("fresh", 2, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
